pattern_tx: RTL and testbench
=============================

# pattern_tx

Serial pattern transmitter: loads a WIDTH-bit pattern (default 10001), then shifts it out MSB-first on a single-bit line for a programmable number of repetitions, with optional idle gap bits between frames. It is the transmit-side counterpart of the serial sequence detectors in this FSM library. It is used as a stimulus source and as a framing generator on single-wire links.

## Interface

Parameters:
- WIDTH, 5, pattern length in bits (2..16).
- PATTERN, 5'b10001, default pattern used when `use_ext` = 0.
- GAP, 0, number of idle (0) bits inserted between consecutive frames (0..15).

Ports:
- clk  in  1  single clock; all sequential logic on posedge.
- reset  in  1  asynchronous, active-low; asserted (0) forces all state to reset values immediately.
- start  in  1  request; sampled only when `ready` = 1.
- use_ext  in  1  1: transmit `data_in`; 0: transmit PATTERN. Sampled with `start`.
- data_in  in  WIDTH  external pattern, captured on accepted `start`.
- reps  in  4  frame repetitions, captured on accepted `start`; 0 means the request is ignored.
- abort  in  1  synchronous cancel of an active transfer.
- ready  out  1  high only in IDLE.
- busy  out  1  high in SHIFT, GAP, DONE.
- out  out  1  serial data; 0 whenever not in SHIFT.
- out_valid  out  1  high exactly during SHIFT cycles.
- done  out  1  one-cycle pulse after the last bit of the last frame.

## Operation

- States: IDLE, SHIFT, GAP, DONE. All outputs are Moore outputs, decoded from registered state, shift register and counters only. No input-to-output combinational path.
- IDLE: `ready` = 1. On a posedge with `start` = 1 and `reps` != 0:
  - capture the pattern (`data_in` or PATTERN) into the shift register and into a pattern hold register;
  - capture `reps` into the repetition counter;
  - clear the bit counter;
  - go to SHIFT.
- IDLE with `start` = 1 and `reps` = 0: no capture, stay in IDLE, no `done`.
- SHIFT: `out` = shift register MSB, `out_valid` = 1. Each cycle the register shifts left with 0 fill and the bit counter increments. After the WIDTH-th bit:
  - if this was the last repetition, go to DONE;
  - else if GAP > 0, go to GAP;
  - else reload from the hold register and stay in SHIFT, giving back-to-back frames with no bubble.
- GAP: `out` = 0, `out_valid` = 0 for exactly GAP cycles. Then reload the shift register from the hold register and go to SHIFT.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- `abort` = 1 in SHIFT or GAP: go to IDLE at the next posedge. No `done` pulse; counters are cleared. `abort` is ignored in IDLE and DONE.
- `start` in any state other than IDLE is ignored; inputs are not re-sampled mid-transfer.
- The repetition counter decrements at the end of each frame. The bit counter is $clog2(WIDTH) bits wide; the gap counter is 4 bits.
- Illegal state encodings return to IDLE.

## Timing

- Reset values: state IDLE, `ready` = 1, `busy` = 0, `out` = 0, `out_valid` = 0, `done` = 0; shift, hold and all counters cleared.
- Reset is asynchronous: deasserting mid-transfer leaves the block in IDLE with no partial frame resumed.
- Accepted `start` at edge k: the first bit (MSB) appears on `out` in the cycle following edge k, i.e. latency 1.
- Frame length is WIDTH cycles of `out_valid`.
- Total `busy` duration = reps*WIDTH + (reps-1)*GAP + 1 cycles.
- `ready` returns high in the cycle after `done`. A new `start` may be accepted on that edge, so the minimum turnaround is 1 idle cycle between transfers.
- `done` is never asserted together with `out_valid`.

## Test plan

- Reset low mid-SHIFT, then release -> all outputs at reset values immediately; `ready` = 1; next `start` behaves normally.
- `start`, `use_ext` = 0, `reps` = 1, GAP = 0 -> `out` = 1,0,0,0,1 over 5 cycles with `out_valid` high, then `done` for 1 cycle, then `ready` = 1. Total `busy` = 6 cycles.
- `reps` = 3, GAP = 0 -> 15 contiguous valid bits 100011000110001; `done` in cycle 16.
- `reps` = 2, GAP = 2, `use_ext` = 1, `data_in` = 5'b11010 -> 1,1,0,1,0, then two cycles of `out` = 0 / `out_valid` = 0, then 1,1,0,1,0, then `done`. Total `busy` = 13.
- `start` with `reps` = 0 -> stays IDLE, `busy` = 0, no `done`. `start` pulsed during SHIFT -> ignored; the stream is unchanged.
- `abort` on the 3rd bit of frame 2 (`reps` = 3) -> next cycle IDLE, `out_valid` = 0, `out` = 0, no `done` pulse.

Source files
------------

// File: rtl/pattern_tx.sv
// pattern_tx: serial pattern transmitter.
//   Captures a WIDTH-bit pattern (external data_in or the PATTERN parameter)
//   and shifts it out MSB-first for 'reps' frames. GAP idle zero bits are
//   inserted between consecutive frames. All outputs are decoded from
//   registered state only.
// Ports:
//   clk        clock, posedge
//   reset      asynchronous, active-low
//   start      transfer request, sampled only in IDLE
//   use_ext    1: send data_in, 0: send PATTERN (sampled with start)
//   data_in    external pattern (sampled with start)
//   reps       frame repetitions; 0 ignores the request
//   abort      cancels an active transfer (SHIFT/GAP)
//   ready      high in IDLE
//   busy       high in SHIFT, GAP, DONE
//   out        serial data, 0 outside SHIFT
//   out_valid  high during SHIFT
//   done       one-cycle pulse after the last bit of the last frame
module pattern_tx #(
   parameter int               WIDTH   = 5,
   parameter logic [WIDTH-1:0] PATTERN = WIDTH'(5'b10001),
   parameter int               GAP     = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             use_ext,
   input  logic [WIDTH-1:0] data_in,
   input  logic [3:0]       reps,
   input  logic             abort,
   output logic             ready,
   output logic             busy,
   output logic             out,
   output logic             out_valid,
   output logic             done
);

   localparam int              BW       = $clog2(WIDTH);
   localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);
   // Only meaningful when GAP > 0; the GAP state is unreachable otherwise.
   localparam logic [3:0]      GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sreg, sreg_nx;
   logic [WIDTH-1:0] hold, hold_nx;
   logic [3:0]       rep_cnt, rep_nx;
   logic [BW-1:0]    bit_cnt, bit_nx;
   logic [3:0]       gap_cnt, gap_nx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         sreg    <= '0;
         hold    <= '0;
         rep_cnt <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         state   <= state_nx;
         sreg    <= sreg_nx;
         hold    <= hold_nx;
         rep_cnt <= rep_nx;
         bit_cnt <= bit_nx;
         gap_cnt <= gap_nx;
      end
   end

   always_comb begin
      state_nx = state;
      sreg_nx  = sreg;
      hold_nx  = hold;
      rep_nx   = rep_cnt;
      bit_nx   = bit_cnt;
      gap_nx   = gap_cnt;
      case (state)
         S_IDLE: begin
            if (start && (reps != 4'd0)) begin
               sreg_nx  = use_ext ? data_in : PATTERN;
               hold_nx  = use_ext ? data_in : PATTERN;
               rep_nx   = reps;
               bit_nx   = '0;
               gap_nx   = '0;
               state_nx = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // abort takes priority over end-of-frame handling
            if (abort) begin
               state_nx = S_IDLE;
               sreg_nx  = '0;
               rep_nx   = '0;
               bit_nx   = '0;
               gap_nx   = '0;
            end else begin
               sreg_nx = {sreg[WIDTH-2:0], 1'b0};
               bit_nx  = bit_cnt + 1'b1;
               if (bit_cnt == BIT_LAST) begin
                  rep_nx = rep_cnt - 1'b1;
                  bit_nx = '0;
                  if (rep_cnt == 4'd1) begin
                     state_nx = S_DONE;
                  end else if (GAP > 0) begin
                     state_nx = S_GAP;
                     gap_nx   = '0;
                  end else begin
                     // back-to-back frame, no bubble
                     sreg_nx = hold;
                  end
               end
            end
         end
         S_GAP: begin
            if (abort) begin
               state_nx = S_IDLE;
               sreg_nx  = '0;
               rep_nx   = '0;
               bit_nx   = '0;
               gap_nx   = '0;
            end else if (gap_cnt == GAP_LAST) begin
               gap_nx   = '0;
               sreg_nx  = hold;
               state_nx = S_SHIFT;
            end else begin
               gap_nx = gap_cnt + 1'b1;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Moore outputs from registered state and shift register only
   assign ready     = (state == S_IDLE);
   assign busy      = (state == S_SHIFT) || (state == S_GAP) || (state == S_DONE);
   assign out_valid = (state == S_SHIFT);
   assign out       = (state == S_SHIFT) && sreg[WIDTH-1];
   assign done      = (state == S_DONE);

endmodule

// File: tb/tb_pattern_tx.sv
module tb_pattern_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       use_ext;
   logic [4:0] data_in;
   logic [3:0] reps;
   logic       abort;

   logic rdy0, bsy0, out0, ov0, dn0;
   logic rdy2, bsy2, out2, ov2, dn2;

   int checks   = 0;
   int failures = 0;

   // expected per-cycle vectors {ready,busy,out_valid,out,done}; [0]=GAP0, [1]=GAP2
   logic [4:0]  expv [2][0:255];
   int          elen [2];
   int          got_busy [2];
   logic [31:0] got_bits [2];
   int          got_nb [2];

   localparam logic [4:0] IDLE_V = 5'b10000;

   typedef struct {
      logic        ue;
      logic [4:0]  d;
      int          r;
      int          ab;
      int          len0;
      int          len2;
      int          nb0;
      logic [31:0] bits0;
      int          nb2;
      logic [31:0] bits2;
   } tv_t;

   tv_t tbl [5];

   pattern_tx #(.WIDTH(5), .GAP(0)) u0 (
      .clk(clk), .reset(reset), .start(start), .use_ext(use_ext),
      .data_in(data_in), .reps(reps), .abort(abort),
      .ready(rdy0), .busy(bsy0), .out(out0), .out_valid(ov0), .done(dn0)
   );

   pattern_tx #(.WIDTH(5), .GAP(2)) u2 (
      .clk(clk), .reset(reset), .start(start), .use_ext(use_ext),
      .data_in(data_in), .reps(reps), .abort(abort),
      .ready(rdy2), .busy(bsy2), .out(out2), .out_valid(ov2), .done(dn2)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] vec(int s);
      if (s == 0) return {rdy0, bsy0, ov0, out0, dn0};
      return {rdy2, bsy2, ov2, out2, dn2};
   endfunction

   task automatic check(input string name, input int c, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, exp);
      end
   endtask

   // Reference: frames of pattern bits, GAP idle cycles between frames,
   // one done cycle; an abort in any but the done cycle cuts the stream there.
   function automatic void build(int s, logic [4:0] pat, int r, int gap, int ab);
      int n;
      n = 0;
      for (int k = 0; k < r; k++) begin
         for (int i = 0; i < 5; i++) begin
            expv[s][n] = {1'b0, 1'b1, 1'b1, pat[4-i], 1'b0};
            n++;
         end
         if (k < r - 1) begin
            for (int g = 0; g < gap; g++) begin
               expv[s][n] = 5'b01000;
               n++;
            end
         end
      end
      if (r > 0) begin
         expv[s][n] = 5'b01001;
         n++;
      end
      if (ab >= 0 && ab < n - 1) n = ab + 1;
      elen[s] = n;
   endfunction

   // Called just after a negedge with both DUTs idle; returns at the negedge
   // of the first idle cycle following the longer stream.
   task automatic run(input logic ue, input logic [4:0] d, input int r, input int ab);
      logic [4:0] pat;
      logic [4:0] v;
      int mn, mx;
      pat = ue ? d : 5'b10001;
      build(0, pat, r, 0, ab);
      build(1, pat, r, 2, ab);
      mn = (elen[0] < elen[1]) ? elen[0] : elen[1];
      mx = (elen[0] > elen[1]) ? elen[0] : elen[1];
      for (int s = 0; s < 2; s++) begin
         got_busy[s] = 0;
         got_bits[s] = '0;
         got_nb[s]   = 0;
      end
      start   = 1'b1;
      use_ext = ue;
      data_in = d;
      reps    = 4'(r);
      abort   = 1'b0;
      for (int c = 0; c <= mx; c++) begin
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            v = vec(s);
            check((s == 0) ? "stream_gap0" : "stream_gap2", c, 32'(v),
                  32'((c < elen[s]) ? expv[s][c] : IDLE_V));
            if (v[3]) got_busy[s]++;
            if (v[2]) begin
               got_bits[s] = {got_bits[s][30:0], v[1]};
               got_nb[s]++;
            end
         end
         // garbage on inputs while both are mid-transfer must have no effect
         start   = (c < mn) ? 1'($urandom_range(0, 1)) : 1'b0;
         use_ext = 1'($urandom_range(0, 1));
         data_in = 5'($urandom);
         reps    = 4'($urandom);
         abort   = (c == ab);
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      tbl[0] = '{1'b0, 5'd0,     1, -1,  6,  6,  5, 32'b10001,           5, 32'b10001};
      tbl[1] = '{1'b0, 5'd0,     3, -1, 16, 20, 15, 32'b100011000110001, 15, 32'b100011000110001};
      tbl[2] = '{1'b1, 5'b11010, 2, -1, 11, 13, 10, 32'b1101011010,      10, 32'b1101011010};
      tbl[3] = '{1'b0, 5'd0,     0, -1,  0,  0,  0, 32'b0,                0, 32'b0};
      tbl[4] = '{1'b0, 5'd0,     3,  7,  8,  8,  8, 32'b10001100,         6, 32'b100011};

      reset   = 1'b0;
      start   = 1'b0;
      use_ext = 1'b0;
      data_in = '0;
      reps    = '0;
      abort   = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_state_gap0", 0, 32'(vec(0)), 32'(IDLE_V));
      check("reset_state_gap2", 0, 32'(vec(1)), 32'(IDLE_V));
      reset = 1'b1;
      @(negedge clk);
      check("post_reset_gap0", 0, 32'(vec(0)), 32'(IDLE_V));

      for (int t = 0; t < 5; t++) begin
         run(tbl[t].ue, tbl[t].d, tbl[t].r, tbl[t].ab);
         check("busy_len_gap0", t, 32'(got_busy[0]), 32'(tbl[t].len0));
         check("busy_len_gap2", t, 32'(got_busy[1]), 32'(tbl[t].len2));
         check("nbits_gap0",    t, 32'(got_nb[0]),   32'(tbl[t].nb0));
         check("bits_gap0",     t, got_bits[0],      tbl[t].bits0);
         check("nbits_gap2",    t, 32'(got_nb[1]),   32'(tbl[t].nb2));
         check("bits_gap2",     t, got_bits[1],      tbl[t].bits2);
      end

      // reset asserted mid-SHIFT takes effect without a clock edge
      start   = 1'b1;
      use_ext = 1'b0;
      reps    = 4'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_shift_valid", 2, 32'(ov0), 32'(1'b1));
      reset = 1'b0;
      #1;
      check("async_reset_gap0", 0, 32'(vec(0)), 32'(IDLE_V));
      check("async_reset_gap2", 0, 32'(vec(1)), 32'(IDLE_V));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("after_release_gap0", 0, 32'(vec(0)), 32'(IDLE_V));
      check("after_release_gap2", 0, 32'(vec(1)), 32'(IDLE_V));
      run(tbl[0].ue, tbl[0].d, tbl[0].r, tbl[0].ab);
      check("restart_bits_gap0", 0, got_bits[0], tbl[0].bits0);
      check("restart_len_gap2",  0, 32'(got_busy[1]), 32'(tbl[0].len2));

      // randomized transfers against the reference
      for (int t = 0; t < 40; t++) begin
         logic       ue;
         logic [4:0] d;
         int         r, ab;
         ue = 1'($urandom_range(0, 1));
         d  = 5'($urandom);
         r  = $urandom_range(0, 5);
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 25)) : -1;
         run(ue, d, r, ab);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
